// File: rtl/spart_tx.sv
// spart_tx: transmit half of the SPART.
// Decodes cpu I/O writes into a one-byte transmit holding register and a
// 16-bit baud divisor (DB), then serialises bytes LSB first on txd.
// Optional build macro SPART_TX_PARITY_EN: when defined, an even-parity bit
// is sent between the data bits and the stop bit (11-bit frames); when
// undefined, frames are plain 8N1 (10 bits).
module spart_tx #(
    parameter logic [15:0] DIV_RESET  = 16'd325,
    parameter int          OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] databus_in,
    output logic       txd,
    output logic       tbr
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SPART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state;
    logic [15:0] db;
    logic [15:0] baud_cnt;
    logic [3:0]  sample_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  hold;
    logic [7:0]  shifter;
    logic        par_bit;

    logic wr;
    logic baud_en;
    logic bit_end;
    logic load;

    // Write strobe, baud enable, end-of-bit and shifter-load conditions.
    // A load happens only with the holding register full (tbr=0): from IDLE
    // at once, or at the end of a stop bit for back-to-back frames.
    always_comb begin
        wr      = iocs & ~iorw;
        baud_en = (state != IDLE) && (baud_cnt == 16'd0);
        bit_end = baud_en && (sample_cnt == 4'(OVERSAMPLE - 1));
        load    = ~tbr && ((state == IDLE) || ((state == STOP) && bit_end));
    end

    // Baud divisor register, written a byte at a time by the cpu.
    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values and block ordering cannot change behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            db <= DIV_RESET;
        end else begin
            if (wr && ioaddr == 2'b10) db[7:0]  <= databus_in;
            if (wr && ioaddr == 2'b11) db[15:8] <= databus_in;
        end
    end

    // Holding register and tbr: accept a byte only when empty, free it on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= 8'h00;
            tbr  <= 1'b1;
        end else if (load) begin
            tbr <= 1'b1;
        end else if (wr && ioaddr == 2'b00 && tbr) begin
            hold <= databus_in;
            tbr  <= 1'b0;
        end
    end

    // Baud and sample counters; both restart on a load so every bit has the
    // same length, and a new DB takes effect at the next reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt   <= 16'd0;
            sample_cnt <= 4'd0;
        end else if (load) begin
            baud_cnt   <= db;
            sample_cnt <= 4'd0;
        end else if (state != IDLE) begin
            if (baud_cnt == 16'd0) begin
                baud_cnt   <= db;
                sample_cnt <= sample_cnt + 4'd1;
            end else begin
                baud_cnt <= baud_cnt - 16'd1;
            end
        end
    end

    // Frame FSM with registered txd; txd follows the state one clock later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            txd     <= 1'b1;
            shifter <= 8'h00;
            par_bit <= 1'b0;
            bit_cnt <= 3'd0;
        end else begin
            case (state)
                START:   txd <= 1'b0;
                DATA:    txd <= shifter[0];
`ifdef SPART_TX_PARITY_EN
                PARITY:  txd <= par_bit;
`endif
                default: txd <= 1'b1;
            endcase

            if (load) begin
                shifter <= hold;
                par_bit <= ^hold;
                bit_cnt <= 3'd0;
                state   <= START;
            end else if (bit_end) begin
                case (state)
                    START: begin
                        bit_cnt <= 3'd0;
                        state   <= DATA;
                    end
                    DATA: begin
                        shifter <= {1'b0, shifter[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef SPART_TX_PARITY_EN
                    PARITY:  state <= STOP;
`endif
                    STOP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
